// File: rtl/hog_block_assembler.sv
// Assembles overlapping 2x2-cell HOG blocks from a raster stream of 9-bin cell histograms.
// Define HOG_BLOCK_SUM_EN to also emit the registered L1 sum of each block.
module hog_block_assembler #(
   parameter int BIN_WIDTH       = 14,
   parameter int IMAGE_WIDTH     = 640,
   parameter int IMAGE_HEIGHT    = 480,
   parameter int HISTOGRAM_WIDTH = BIN_WIDTH * 9,
   parameter int BLOCK_WIDTH     = HISTOGRAM_WIDTH * 4,
   parameter int SUM_WIDTH       = BIN_WIDTH + 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [HISTOGRAM_WIDTH-1:0] histogram,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BLOCK_WIDTH-1:0]     block,
   output logic [SUM_WIDTH-1:0]       block_sum,
   output logic                       block_last
);

   localparam int CELLS_PER_ROW = IMAGE_WIDTH / 8;
   localparam int CELL_ROWS     = IMAGE_HEIGHT / 8;
   localparam int COL_W         = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;
   localparam int ROW_W         = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(CELLS_PER_ROW - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CELL_ROWS - 1);

   typedef enum logic {FILL, STREAM} phase_e;

   phase_e                     phase_q, phase_d;
   logic [COL_W-1:0]           col_q, col_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic                       out_valid_q, out_valid_d;
   logic                       block_last_q, block_last_d;
   logic [BLOCK_WIDTH-1:0]     block_q, block_d;
   logic [HISTOGRAM_WIDTH-1:0] left_cur_q, left_cur_d;
   logic [HISTOGRAM_WIDTH-1:0] left_up_q, left_up_d;
   logic [HISTOGRAM_WIDTH-1:0] line_mem [CELLS_PER_ROW];
   logic [HISTOGRAM_WIDTH-1:0] up_cell;
   logic [BLOCK_WIDTH-1:0]     new_block;
   logic                       accept, emit, frame_end;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign emit      = (phase_q == STREAM) && (col_q != '0);
   assign frame_end = (row_q == LAST_ROW) && (col_q == LAST_COL);
   // Read-before-write: this returns the previous row's cell even while entry[col] is being overwritten.
   assign up_cell   = line_mem[col_q];
   assign new_block = {histogram, left_cur_q, up_cell, left_up_q};

   always_comb begin
      phase_d = phase_q;
      col_d   = col_q;
      row_d   = row_q;
      if (accept) begin
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = frame_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         phase_d = (row_d == '0) ? FILL : STREAM;
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q && !out_ready;
      block_d      = block_q;
      block_last_d = block_last_q;
      left_cur_d   = left_cur_q;
      left_up_d    = left_up_q;
      if (accept) begin
         out_valid_d = emit;
         left_cur_d  = histogram;
         left_up_d   = up_cell;
         if (emit) begin
            block_d      = new_block;
            block_last_d = frame_end;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_q      <= FILL;
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         block_q      <= '0;
         block_last_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         block_q      <= block_d;
         block_last_q <= block_last_d;
      end
   end

   // Row 0 of every frame rewrites all entries before they are read, so no clear is needed.
   always_ff @(posedge clk) begin
      left_cur_q <= left_cur_d;
      left_up_q  <= left_up_d;
      if (accept) line_mem[col_q] <= histogram;
   end

   assign out_valid  = out_valid_q;
   assign block      = block_q;
   assign block_last = block_last_q;

`ifdef HOG_BLOCK_SUM_EN
   function automatic logic [SUM_WIDTH-1:0] bin_sum(input logic [BLOCK_WIDTH-1:0] b);
      logic [SUM_WIDTH-1:0] acc;
      acc = '0;
      for (int k = 0; k < 36; k++) acc = acc + SUM_WIDTH'(b[k*BIN_WIDTH +: BIN_WIDTH]);
      return acc;
   endfunction

   logic [SUM_WIDTH-1:0] block_sum_q, block_sum_d;

   always_comb begin
      block_sum_d = block_sum_q;
      if (accept && emit) block_sum_d = bin_sum(new_block);
   end

   always_ff @(posedge clk) begin
      if (!rst) block_sum_q <= '0;
      else      block_sum_q <= block_sum_d;
   end

   assign block_sum = block_sum_q;
`else
   assign block_sum = '0;
`endif

endmodule

// File: tb/tb_hog_block_assembler.sv
// Randomized self-checking bench for hog_block_assembler on a 4x3-cell image.
module tb_hog_block_assembler;

   localparam int BIN_W = 14;
   localparam int HW    = BIN_W * 9;
   localparam int BW    = HW * 4;
   localparam int SW    = BIN_W + 6;
   localparam int CPR   = 4;
   localparam int CR    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [HW-1:0] histogram = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [BW-1:0] block;
   logic [SW-1:0] block_sum;
   logic          block_last;

   typedef struct {
      logic [BW-1:0] blk;
      logic          last;
      logic [SW-1:0] sum;
   } exp_t;

   exp_t          exp_q[$];
   logic [HW-1:0] cells [CR][CPR];
   int            n_checks = 0;
   int            n_pass = 0;
   int            n_blocks = 0;
   int            ready_mode = 0;
   int            stall_left = 0;
   bit            mon_en = 0;
   bit            prev_hold = 0;
   logic [BW-1:0] held_block;

   hog_block_assembler #(
      .BIN_WIDTH(BIN_W), .IMAGE_WIDTH(32), .IMAGE_HEIGHT(24)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .histogram(histogram), .out_valid(out_valid), .out_ready(out_ready),
      .block(block), .block_sum(block_sum), .block_last(block_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, expv);
   endtask

   function automatic logic [HW-1:0] fill(input int v);
      logic [HW-1:0] h;
      for (int k = 0; k < 9; k++) h[k*BIN_W +: BIN_W] = BIN_W'(v);
      return h;
   endfunction

   function automatic logic [SW-1:0] cell_sum(input logic [HW-1:0] h);
      logic [SW-1:0] s = '0;
      for (int k = 0; k < 9; k++) s = s + SW'(h[k*BIN_W +: BIN_W]);
      return s;
   endfunction

   // Reference: every interior cell (r>=1, c>=1) closes one block built from its 2x2 neighbourhood.
   task automatic model_frame();
      exp_t e;
      for (int r = 1; r < CR; r++)
         for (int c = 1; c < CPR; c++) begin
            e.blk  = {cells[r][c], cells[r][c-1], cells[r-1][c], cells[r-1][c-1]};
            e.last = (r == CR - 1) && (c == CPR - 1);
`ifdef HOG_BLOCK_SUM_EN
            e.sum  = cell_sum(cells[r][c]) + cell_sum(cells[r][c-1]) +
                     cell_sum(cells[r-1][c]) + cell_sum(cells[r-1][c-1]);
`else
            e.sum  = '0;
`endif
            exp_q.push_back(e);
         end
   endtask

   task automatic pattern_cells();
      for (int r = 0; r < CR; r++)
         for (int c = 0; c < CPR; c++) cells[r][c] = fill(r * CPR + c + 1);
   endtask

   task automatic random_cells();
      for (int r = 0; r < CR; r++)
         for (int c = 0; c < CPR; c++)
            for (int k = 0; k < 9; k++) cells[r][c][k*BIN_W +: BIN_W] = BIN_W'($urandom_range(16383));
   endtask

   task automatic push_cell(input logic [HW-1:0] h, input int pct, output bit ok);
      int g = 0;
      ok = 0;
      while ($urandom_range(99) >= pct) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      histogram = h;
      while (!ok && g < 500) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         g++;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int pct, input bit chk, input int ncells);
      bit ok;
      model_frame();
      for (int i = 0; i < ncells; i++) begin
         push_cell(cells[i / CPR][i % CPR], pct, ok);
         if (!ok) check("in_timeout", 0, 1);
         if (chk) check($sformatf("emit_r%0d_c%0d", i / CPR, i % CPR), out_valid,
                        (i / CPR >= 1) && (i % CPR >= 1));
         if (chk && i == CPR + 1)
            check("first_block", block, {fill(6), fill(5), fill(2), fill(1)});
      end
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() > 0 && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: out_ready = 1'($urandom_range(1));
         2: if (out_valid && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else out_ready = 1'b1;
         default: out_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && rst) begin
         if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_block", block, held_block);
         end
         if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_block", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("block", block, e.blk);
               check("block_last", block_last, e.last);
               check("block_sum", block_sum, e.sum);
               n_blocks++;
            end
         end
         prev_hold  = out_valid && !out_ready;
         held_block = block;
      end else prev_hold = 0;
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_block", block, 0);
      check("rst_block_last", block_last, 0);
      check("rst_block_sum", block_sum, 0);
      check("rst_in_ready", in_ready, 1);
      mon_en = 1;

      pattern_cells();
      base = n_blocks;
      run_frame(100, 1, CR * CPR);
      drain();
      check("frame1_count", n_blocks - base, 6);

      base = n_blocks;
      ready_mode = 2;
      stall_left = 5;
      run_frame(100, 0, CR * CPR);
      drain();
      ready_mode = 0;
      check("stall_count", n_blocks - base, 6);
      check("stall_done", stall_left, 0);

      base = n_blocks;
      run_frame(100, 1, CR * CPR);
      run_frame(100, 1, CR * CPR);
      drain();
      check("two_frame_count", n_blocks - base, 12);

      base = n_blocks;
      ready_mode = 1;
      for (int f = 0; f < 3; f++) begin
         random_cells();
         run_frame(50, 0, CR * CPR);
      end
      ready_mode = 0;
      drain();
      check("random_count", n_blocks - base, 18);

      pattern_cells();
      run_frame(100, 1, 2 * CPR + 2);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      check("midrst_out_valid", out_valid, 0);
      base = n_blocks;
      run_frame(100, 1, CR * CPR);
      drain();
      check("after_rst_count", n_blocks - base, 6);

      for (int r = 0; r < CR; r++)
         for (int c = 0; c < CPR; c++) cells[r][c] = fill(16383);
      base = n_blocks;
      run_frame(100, 0, CPR + 2);
      check("sat_first_valid", out_valid, 1);
`ifdef HOG_BLOCK_SUM_EN
      check("sat_first_sum", block_sum, 589788);
`else
      check("sat_first_sum", block_sum, 0);
`endif
      for (int i = CPR + 2; i < CR * CPR; i++) begin
         bit ok;
         push_cell(cells[i / CPR][i % CPR], 100, ok);
         if (!ok) check("in_timeout", 0, 1);
      end
      drain();
      check("sat_count", n_blocks - base, 6);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
